// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide, one bit per cycle.
// Latency WIDTH+1 cycles from accept to done (1 for div-by-zero/overflow); start is ignored while busy.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [2:0]         op;
    logic               neg;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   bm;

    // Operand decode at accept
    logic             is_div, a_sgn_op, b_sgn_op, sa, sb, neg_in, div_zero, ovf;
    logic [WIDTH-1:0] a_mag, b_mag;

    always_comb begin
        is_div   = funct3[2];
        a_sgn_op = is_div ? ~funct3[0] : (funct3 != 3'b011);
        b_sgn_op = is_div ? ~funct3[0] : ~funct3[1];
        sa       = a_sgn_op & op_a[WIDTH-1];
        sb       = b_sgn_op & op_b[WIDTH-1];
        a_mag    = sa ? (~op_a + 1'b1) : op_a;
        b_mag    = sb ? (~op_b + 1'b1) : op_b;
        neg_in   = (is_div && funct3[1]) ? sa : (sa ^ sb);
        div_zero = is_div && (op_b == '0);
        ovf      = is_div && !funct3[0] && (op_a == SMIN) && (op_b == '1);
    end

    // One iteration: multiply keeps {partial, multiplier} and shifts right;
    // divide keeps {remainder, quotient} and shifts left.
    logic [WIDTH:0]     sum, remsh;
    logic [WIDTH-1:0]   diff;
    logic               ge;
    logic [2*WIDTH-1:0] acc_nxt;

    always_comb begin
        sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, bm} : '0);
        remsh = acc[2*WIDTH-1:WIDTH-1];
        ge    = remsh >= {1'b0, bm};
        diff  = remsh[WIDTH-1:0] - bm;
        if (op[2])
            acc_nxt = {(ge ? diff : remsh[WIDTH-1:0]), acc[WIDTH-2:0], ge};
        else
            acc_nxt = {sum, acc[WIDTH-1:1]};
    end

    // Final sign correction and word select
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   sel, res_nxt;

    always_comb begin
        prod    = neg ? (~acc + 1'b1) : acc;
        sel     = op[1] ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
        res_nxt = '0;
        if (op[2])
            res_nxt = neg ? (~sel + 1'b1) : sel;
        else if (op == 3'b000)
            res_nxt = prod[WIDTH-1:0];
        else
            res_nxt = prod[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = (div_zero || ovf) ? S_DONE : S_CALC;
            S_CALC:  if (cnt == '0) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op     <= '0;
            neg    <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            bm     <= '0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    op  <= funct3;
                    cnt <= CW'(WIDTH - 1);
                    // Special cases preload acc so the DONE select yields the answer unsigned
                    if (div_zero) begin
                        neg <= 1'b0;
                        acc <= {op_a, {WIDTH{1'b1}}};
                    end else if (ovf) begin
                        neg <= 1'b0;
                        acc <= {{WIDTH{1'b0}}, SMIN};
                    end else if (is_div) begin
                        neg <= neg_in;
                        acc <= {{WIDTH{1'b0}}, a_mag};
                        bm  <= b_mag;
                    end else begin
                        neg <= neg_in;
                        acc <= {{WIDTH{1'b0}}, b_mag};
                        bm  <= a_mag;
                    end
                end
                S_CALC: begin
                    acc <= acc_nxt;
                    cnt <= cnt - 1'b1;
                end
                S_DONE: begin
                    result <= res_nxt;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic        busy, done;
    logic [31:0] result;

    int n_checks = 0;
    int n_errors = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op, scramble inputs after acceptance, measure latency and busy cycles.
    task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        int busy_cnt;
        lat = 0;
        @(negedge clk);
        start = 1'b1; funct3 = f; op_a = a; op_b = b;
        @(posedge clk); #1;
        start = 1'b0; funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
        busy_cnt = busy ? 1 : 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
            if (busy) busy_cnt++;
        end
        check({tag, " result"}, result, exp);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat));
    endtask

    initial begin
        int lat;
        int done_cnt;
        rst_n = 1'b0; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset result", result, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Multiply
        do_op("MUL 7*-7",        3'b000, 32'd7,        32'hFFFF_FFF9, 32'hFFFF_FFCF, 33);
        do_op("MULH min*min",    3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        do_op("MULHU max*max",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        do_op("MULHSU -1*2",     3'b010, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 33);

        // Divide
        do_op("DIV -7/2",        3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33);
        do_op("REM -7/2",        3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33);
        do_op("DIVU 100/7",      3'b101, 32'd100,      32'd7,        32'd14,        33);
        do_op("REMU 100/7",      3'b111, 32'd100,      32'd7,        32'd2,         33);
        do_op("DIV 7/-2",        3'b100, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);

        // Special cases
        do_op("DIVU 5/0",        3'b101, 32'd5,        32'd0,        32'hFFFF_FFFF, 1);
        do_op("REM 5/0",         3'b110, 32'd5,        32'd0,        32'd5,         1);
        do_op("DIV 5/0",         3'b100, 32'd5,        32'd0,        32'hFFFF_FFFF, 1);
        do_op("DIV ovf",         3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        do_op("REM ovf",         3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

        // Result is held while idle
        repeat (4) @(posedge clk);
        #1;
        check("result hold", result, 32'd0);

        // Reset in the middle of CALC
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; op_a = 32'd9; op_b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset busy", {31'b0, busy}, 32'd0);
        check("midreset done", {31'b0, done}, 32'd0);
        check("midreset result", result, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        check("no done after reset", 32'(done_cnt), 32'd0);
        do_op("MUL 3*4 after reset", 3'b000, 32'd3, 32'd4, 32'd12, 33);

        // start pulsed mid-CALC is ignored
        @(negedge clk);
        start = 1'b1; funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (i == 5) begin
                start = 1'b1; funct3 = 3'b000; op_a = 32'd3; op_b = 32'd4;
            end
            if (i == 6) start = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
        end
        check("ignored start result", result, 32'd14);
        check("ignored start latency", 32'(lat), 32'd33);

        // Back-to-back: next start lands in the cycle after done
        do_op("b2b MULHU", 3'b011, 32'h0001_0000, 32'h0003_0000, 32'd3, 33);
        do_op("b2b REMU",  3'b111, 32'hFFFF_FFFF, 32'd10,        32'd5, 33);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
